// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified memory-port arbiter.
// The request record is sized by ARB_XLEN; the top's XLEN is expected to match it.
package mem_port_arbiter_pkg;

  localparam int ARB_XLEN    = 32;
  localparam int MEM_WSTRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                   we;
    logic [ARB_XLEN-1:0]    addr;
    logic [ARB_XLEN-1:0]    wdata;
    logic [MEM_WSTRB_W-1:0] wstrb;
  } mem_req_t;

  // Byte enables only mean something on writes; reads always present zero.
  function automatic logic [MEM_WSTRB_W-1:0] mem_strb(input logic is_write,
                                                      input logic [MEM_WSTRB_W-1:0] strb);
    return is_write ? strb : {MEM_WSTRB_W{1'b0}};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Per-access watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1 (never when TIMEOUT_CYCLES is 0).
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] count_r;

  // Cycle counter, saturating at the limit so it never wraps during a long stall
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LIMIT)) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign timeout = WD_ON && enable && (count_r == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, data first,
// with a streak limit so a pending fetch is never starved and a watchdog per access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN           = ARB_XLEN,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_req,
  input  logic [XLEN-1:0]        i_addr,
  output logic [XLEN-1:0]        i_rdata,
  output logic                   i_valid,
  output logic                   i_err,
  output logic                   i_stall,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [XLEN-1:0]        d_addr,
  input  logic [XLEN-1:0]        d_wdata,
  input  logic [MEM_WSTRB_W-1:0] d_wstrb,
  output logic [XLEN-1:0]        d_rdata,
  output logic                   d_valid,
  output logic                   d_err,
  output logic                   d_stall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic [MEM_WSTRB_W-1:0] mem_wstrb,
  input  logic [XLEN-1:0]        mem_rdata,
  input  logic                   mem_ready,
  output logic                   busy
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state_r, state_next_s;
  logic [STREAK_W-1:0] streak_r, streak_next_s;
  mem_req_t            req_r, req_next_s;
  logic                grant_s, done_s, timeout_s;

  // Grant decision in IDLE, completion/abort detection while busy
  always_comb begin
    state_next_s  = state_r;
    streak_next_s = streak_r;
    req_next_s    = req_r;
    grant_s       = 1'b0;
    done_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_req && !(i_req && (streak_r == STREAK_MAX))) begin
          grant_s      = 1'b1;
          state_next_s = BUSY_D;
          req_next_s   = '{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: mem_strb(d_we, d_wstrb)};
          if (!i_req) begin
            streak_next_s = '0;
          end else if (streak_r != STREAK_MAX) begin
            streak_next_s = streak_r + 1'b1;
          end else begin
            streak_next_s = streak_r;
          end
        end else if (i_req) begin
          grant_s       = 1'b1;
          state_next_s  = BUSY_I;
          req_next_s    = '{we: 1'b0, addr: i_addr, wdata: '0, wstrb: '0};
          streak_next_s = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        done_s = mem_ready || timeout_s;
        if (done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, streak counter and latched request fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      streak_r <= '0;
      req_r    <= '0;
    end else begin
      state_r  <= state_next_s;
      streak_r <= streak_next_s;
      req_r    <= req_next_s;
    end
  end

  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_s),
    .enable  (busy),
    .timeout (timeout_s)
  );

  assign busy      = (state_r != IDLE);
  assign mem_req   = busy;
  assign mem_we    = req_r.we;
  assign mem_addr  = req_r.addr;
  assign mem_wdata = req_r.wdata;
  assign mem_wstrb = req_r.wstrb;

  // A ready memory wins over a same-cycle timeout, so err implies no ready
  assign i_valid = (state_r == BUSY_I) && done_s;
  assign d_valid = (state_r == BUSY_D) && done_s;
  assign i_err   = i_valid && !mem_ready;
  assign d_err   = d_valid && !mem_ready;
  assign i_rdata = ((state_r == BUSY_I) && mem_ready) ? mem_rdata : '0;
  assign d_rdata = ((state_r == BUSY_D) && mem_ready) ? mem_rdata : '0;
  assign i_stall = i_req && !i_valid;
  assign d_stall = d_req && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            i_req, d_req, d_we, mem_ready;
  logic [XLEN-1:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]      d_wstrb;
  logic [XLEN-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic            i_valid, i_err, i_stall, d_valid, d_err, d_stall;
  logic            mem_req, mem_we, busy;
  logic [3:0]      mem_wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .i_err(i_err), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_wstrb = 4'h0; mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0ABC; d_wdata = 32'h1111_2222; d_wstrb = 4'hF;
    step();
    reset = 1'b1;
    step();
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy} !== 71'h0) begin
      failures++;
      $display("FAIL reset_mem_fields got=%h exp=0", {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy});
    end
    checks++;
    if ({i_valid, i_err, d_valid, d_err} !== 4'h0) begin
      failures++;
      $display("FAIL reset_valids got=%b exp=0000", {i_valid, i_err, d_valid, d_err});
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    #1;
    checks++;
    if ({i_stall, mem_req, busy} !== 3'b100) begin
      failures++;
      $display("FAIL fetch_grant_cycle got=%b exp=100", {i_stall, mem_req, busy});
    end
    step();
    mem_ready = 1'b1; mem_rdata = 32'h0051_3093;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 32'h0000_0010, 4'h0}) begin
      failures++;
      $display("FAIL fetch_mem_fields got=%h", {mem_req, mem_we, mem_addr, mem_wstrb});
    end
    checks++;
    if ({i_valid, i_err, i_stall, i_rdata} !== {3'b100, 32'h0051_3093}) begin
      failures++;
      $display("FAIL fetch_complete got=%h exp=%h", {i_valid, i_err, i_stall, i_rdata}, {3'b100, 32'h0051_3093});
    end
    step();
    i_req = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, i_valid, i_stall} !== 4'b0000) begin
      failures++;
      $display("FAIL fetch_after got=%b exp=0000", {mem_req, busy, i_valid, i_stall});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100; d_wstrb = 4'hF;
    step();
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wstrb, d_valid, i_valid, i_stall, d_stall} !==
        {2'b10, 32'h0000_0100, 4'h0, 4'b0011}) begin
      failures++;
      $display("FAIL simul_d_first got=%h", {mem_req, mem_we, mem_addr, mem_wstrb, d_valid, i_valid, i_stall, d_stall});
    end
    step();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({d_valid, d_err, i_valid, d_rdata} !== {3'b100, 32'h1234_5678}) begin
      failures++;
      $display("FAIL simul_d_done got=%h", {d_valid, d_err, i_valid, d_rdata});
    end
    step();
    d_req = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if ({busy, mem_req, i_valid, i_stall} !== 4'b0001) begin
      failures++;
      $display("FAIL simul_idle_gap got=%b exp=0001", {busy, mem_req, i_valid, i_stall});
    end
    step();
    #1;
    checks++;
    if ({mem_req, mem_addr, i_valid} !== {1'b1, 32'h0000_0040, 1'b0}) begin
      failures++;
      $display("FAIL simul_i_start got=%h", {mem_req, mem_addr, i_valid});
    end
    step();
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #1;
    checks++;
    if ({i_valid, i_err, d_valid, i_rdata} !== {3'b100, 32'h0BAD_F00D}) begin
      failures++;
      $display("FAIL simul_i_done got=%h", {i_valid, i_err, d_valid, i_rdata});
    end
    step();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic exp_i;
    logic [XLEN-1:0] exp_addr;
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
    for (int k = 0; k < 10; k++) begin
      step();
      mem_ready = 1'b1; mem_rdata = 32'(k);
      #1;
      exp_i = ((k % (MAXS + 1)) == MAXS);
      exp_addr = exp_i ? i_addr : d_addr;
      checks++;
      if ({mem_addr, i_valid, d_valid} !== {exp_addr, exp_i, !exp_i}) begin
        failures++;
        $display("FAIL starve_k%0d got addr=%h iv=%b dv=%b exp addr=%h iv=%b", k, mem_addr, i_valid, d_valid, exp_addr, exp_i);
      end
      step();
      mem_ready = 1'b0;
      if (!exp_i) d_addr = d_addr + 32'd4;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'hF;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    for (int k = 1; k <= TMO; k++) begin
      #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {2'b11, 32'h0000_0200, 32'hCAFE_F00D, 4'hF}) begin
        failures++;
        $display("FAIL timeout_fields_c%0d got=%h", k, {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb});
      end
      checks++;
      if ({d_valid, d_err, d_rdata} !== ((k == TMO) ? {2'b11, 32'h0} : {2'b00, 32'h0})) begin
        failures++;
        $display("FAIL timeout_c%0d got v=%b e=%b rd=%h exp v=e=%0d rd=0", k, d_valid, d_err, d_rdata, (k == TMO));
      end
      step();
    end
    d_req = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, d_valid} !== 3'b000) begin
      failures++;
      $display("FAIL timeout_release got=%b exp=000", {mem_req, busy, d_valid});
    end
    i_req = 1'b1; i_addr = 32'h0000_0080;
    step();
    mem_ready = 1'b1; mem_rdata = 32'h0000_600D;
    #1;
    checks++;
    if ({i_valid, i_err, i_rdata} !== {2'b10, 32'h0000_600D}) begin
      failures++;
      $display("FAIL timeout_next_fetch got=%h", {i_valid, i_err, i_rdata});
    end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_0300;
    step();
    step();
    step();
    step();
    #1;
    checks++;
    if ({mem_req, i_valid} !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_waiting got=%b exp=10", {mem_req, i_valid});
    end
    reset = 1'b1; i_req = 1'b0;
    step();
    #1;
    checks++;
    if ({mem_req, busy, i_valid, mem_addr} !== 35'h0) begin
      failures++;
      $display("FAIL rstmid_abandon got=%h exp=0", {mem_req, busy, i_valid, mem_addr});
    end
    reset = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0304;
    step();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    #1;
    checks++;
    if ({mem_req, mem_addr, i_valid, i_rdata} !== {1'b1, 32'h0000_0304, 1'b1, 32'h0000_0077}) begin
      failures++;
      $display("FAIL rstmid_refetch got=%h", {mem_req, mem_addr, i_valid, i_rdata});
    end
    step();
    idle_inputs();
  endtask

  task automatic test_byte_write();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0302; d_wdata = 32'h00AB_0000; d_wstrb = 4'b0100;
    step();
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({mem_we, mem_wstrb, mem_addr, mem_wdata, d_valid} !== {1'b1, 4'b0100, 32'h0000_0302, 32'h00AB_0000, 1'b1}) begin
      failures++;
      $display("FAIL byte_write got=%h", {mem_we, mem_wstrb, mem_addr, mem_wdata, d_valid});
    end
    step();
    mem_ready = 1'b0; d_we = 1'b0; d_wstrb = 4'hF; d_addr = 32'h0000_0304;
    step();
    mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    checks++;
    if ({mem_we, mem_wstrb, mem_addr, d_valid, d_rdata} !== {1'b0, 4'h0, 32'h0000_0304, 1'b1, 32'h5555_AAAA}) begin
      failures++;
      $display("FAIL byte_read_after got=%h", {mem_we, mem_wstrb, mem_addr, d_valid, d_rdata});
    end
    step();
    idle_inputs();
  endtask

  task automatic test_random();
    int owner = 0;
    int streak = 0;
    int wd = 0;
    logic e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0] e_wstrb;
    bit i_done = 1'b0;
    bit d_done = 1'b0;
    bit done, ev_i, ev_d;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (i_done || !i_req) begin
        i_req = ($urandom_range(0, 2) != 0); i_addr = $urandom;
      end
      if (d_done || !d_req) begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
      end
      mem_ready = ($urandom_range(0, 2) == 0); mem_rdata = $urandom;
      #1;
      done = (owner != 0) && (mem_ready || (wd == TMO - 1));
      ev_i = (owner == 1) && done;
      ev_d = (owner == 2) && done;
      checks++;
      if (mem_req !== (owner != 0) || busy !== (owner != 0)) begin
        failures++;
        $display("FAIL rnd_busy c=%0d got req=%b busy=%b exp owner=%0d", c, mem_req, busy, owner);
      end
      if (owner != 0) begin
        checks++;
        if ({mem_we, mem_addr, mem_wstrb} !== {e_we, e_addr, e_wstrb} || (owner == 2 && mem_wdata !== e_wdata)) begin
          failures++;
          $display("FAIL rnd_fields c=%0d got=%h/%h exp=%h/%h", c, {mem_we, mem_addr, mem_wstrb}, mem_wdata, {e_we, e_addr, e_wstrb}, e_wdata);
        end
      end
      checks++;
      if ({i_valid, i_err, d_valid, d_err} !== {ev_i, ev_i && !mem_ready, ev_d, ev_d && !mem_ready}) begin
        failures++;
        $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, {i_valid, i_err, d_valid, d_err}, {ev_i, ev_i && !mem_ready, ev_d, ev_d && !mem_ready});
      end
      checks++;
      if (i_rdata !== ((owner == 1 && mem_ready) ? mem_rdata : 32'h0) ||
          d_rdata !== ((owner == 2 && mem_ready) ? mem_rdata : 32'h0)) begin
        failures++;
        $display("FAIL rnd_rdata c=%0d got i=%h d=%h", c, i_rdata, d_rdata);
      end
      checks++;
      if ({i_stall, d_stall} !== {i_req && !ev_i, d_req && !ev_d}) begin
        failures++;
        $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, {i_stall, d_stall}, {i_req && !ev_i, d_req && !ev_d});
      end
      i_done = ev_i;
      d_done = ev_d;
      if (owner == 0) begin
        if (d_req && !(i_req && streak >= MAXS)) begin
          owner = 2; wd = 0;
          e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_wstrb = d_we ? d_wstrb : 4'h0;
          streak = i_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        end else if (i_req) begin
          owner = 1; wd = 0; streak = 0;
          e_we = 1'b0; e_addr = i_addr; e_wdata = 32'h0; e_wstrb = 4'h0;
        end
      end else if (done) begin
        owner = 0;
      end else begin
        wd++;
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_byte_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
